// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions for the writeback stage: widths, register indices and
// the writeback result-select encodings.
package wb_regfile_pkg;

    localparam int PC_BITS    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // mem_to_reg encodings; 2'b11 is reserved and behaves like ALU select
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle plus decode read ports and forwarding outputs.
interface wb_regfile_if #(
    parameter int DATA_W     = wb_regfile_pkg::PC_BITS,
    parameter int REG_ADDR_W = wb_regfile_pkg::REG_ADDR_W
);

    logic                  reg_write_wb;
    logic [1:0]            mem_to_reg_wb;
    logic [DATA_W-1:0]     alu_out_wb;
    logic [DATA_W-1:0]     read_data_wb;
    logic [DATA_W-1:0]     pc_plus_4wb;
    logic [REG_ADDR_W-1:0] write_reg_wb;
    logic                  valid_wb;
    logic [REG_ADDR_W-1:0] ra1;
    logic [REG_ADDR_W-1:0] ra2;

    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     result_wb;
    logic                  fwd_we_wb;
    logic [REG_ADDR_W-1:0] fwd_dst_wb;
    logic [31:0]           instret;

    modport master (
        output reg_write_wb, mem_to_reg_wb, alu_out_wb, read_data_wb, pc_plus_4wb,
               write_reg_wb, valid_wb, ra1, ra2,
        input  rd1, rd2, result_wb, fwd_we_wb, fwd_dst_wb, instret
    );

    modport slave (
        input  reg_write_wb, mem_to_reg_wb, alu_out_wb, read_data_wb, pc_plus_4wb,
               write_reg_wb, valid_wb, ra1, ra2,
        output rd1, rd2, result_wb, fwd_we_wb, fwd_dst_wb, instret
    );

endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// 2-read/1-write register file with hardwired-zero entry 0 and same-cycle
// write-through bypass on both read ports.
module regfile_2r1w #(
    parameter int DATA_W     = wb_regfile_pkg::PC_BITS,
    parameter int REG_ADDR_W = wb_regfile_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = wb_regfile_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2
);

    import wb_regfile_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // NOTE: the whole array is cleared on reset, so it is built from flops
    // rather than a RAM macro; a RAM cannot be reset in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != ZERO_IDX) begin
            regs[wa] <= wd;
        end
    end

    // Index 0 wins over the bypass so $0 reads as zero even if a write targets it.
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == ZERO_IDX) begin
            rd1 = '0;
        end else if (we && ra1 == wa) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == ZERO_IDX) begin
            rd2 = '0;
        end else if (we && ra2 == wa) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the register file,
// drives the forwarding outputs and counts retired instructions.
module wb_regfile #(
    parameter int DATA_W     = wb_regfile_pkg::PC_BITS,
    parameter int REG_ADDR_W = wb_regfile_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = wb_regfile_pkg::NUM_REGS
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);

    import wb_regfile_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] result;
    logic              we;
    logic [31:0]       instret_cnt;

    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational for every select value, so no latch is inferred.
    always_comb begin
        result = bus.alu_out_wb;
        case (bus.mem_to_reg_wb)
            WB_SEL_MEM: result = bus.read_data_wb;
            WB_SEL_PC4: result = bus.pc_plus_4wb;
            default:    result = bus.alu_out_wb;
        endcase
    end

    // Bubbles and writes to $0 are invisible to both the file and the forwarding unit.
    assign we = bus.reg_write_wb & bus.valid_wb & (bus.write_reg_wb != ZERO_IDX);

    assign bus.result_wb  = result;
    assign bus.fwd_we_wb  = we;
    assign bus.fwd_dst_wb = we ? bus.write_reg_wb : ZERO_IDX;

    regfile_2r1w #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .wa  (bus.write_reg_wb),
        .wd  (result),
        .ra1 (bus.ra1),
        .ra2 (bus.ra2),
        .rd1 (bus.rd1),
        .rd2 (bus.rd2)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_cnt <= '0;
        end else if (bus.valid_wb) begin
            instret_cnt <= instret_cnt + 32'd1;
        end
    end

    assign bus.instret = instret_cnt;

    a_fwd_dst_idle: assert property (@(posedge clk) !bus.fwd_we_wb |-> bus.fwd_dst_wb == ZERO_IDX);
    a_zero_read1:   assert property (@(posedge clk) bus.ra1 == ZERO_IDX |-> bus.rd1 == '0);
    a_zero_read2:   assert property (@(posedge clk) bus.ra2 == ZERO_IDX |-> bus.rd2 == '0);

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, reset/wrap sequences and
// randomized traffic against an array-based reference model.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [4:0]  dst;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_res;
        logic        e_we;
        logic [4:0]  e_dst;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_result();
        case (bus.mem_to_reg_wb)
            2'b01:   return bus.read_data_wb;
            2'b10:   return bus.pc_plus_4wb;
            default: return bus.alu_out_wb;
        endcase
    endfunction

    function automatic logic m_we();
        return bus.reg_write_wb && bus.valid_wb && (bus.write_reg_wb != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (m_we() && ra == bus.write_reg_wb) return m_result();
        return m_regs[ra];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    task automatic set_in(input logic valid, input logic rw, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                          input logic [4:0] dst, input logic [4:0] ra1, input logic [4:0] ra2);
        bus.valid_wb      = valid;
        bus.reg_write_wb  = rw;
        bus.mem_to_reg_wb = sel;
        bus.alu_out_wb    = alu;
        bus.read_data_wb  = mem;
        bus.pc_plus_4wb   = pc4;
        bus.write_reg_wb  = dst;
        bus.ra1           = ra1;
        bus.ra2           = ra2;
    endtask

    task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, ra1, ra2);
    endtask

    // Advance one rising edge, updating the model from the inputs held across it.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (m_we()) m_regs[bus.write_reg_wb] = m_result();
            if (bus.valid_wb) m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, " rd1"},     bus.rd1,                m_read(bus.ra1));
        check({tag, " rd2"},     bus.rd2,                m_read(bus.ra2));
        check({tag, " result"},  bus.result_wb,          m_result());
        check({tag, " fwd_we"},  {31'd0, bus.fwd_we_wb}, {31'd0, m_we()});
        check({tag, " fwd_dst"}, {27'd0, bus.fwd_dst_wb},
              {27'd0, (m_we() ? bus.write_reg_wb : 5'd0)});
        check({tag, " instret"}, bus.instret,            m_cnt);
    endtask

    initial begin
        // valid rw sel alu mem pc4 dst ra1 ra2 | rd1 rd2 result we dst instret-after-edge
        tbl[0] = '{1'b1, 1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd7, 5'd7, 5'd0,
                   32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b1, 5'd7, 32'd1};
        tbl[1] = '{1'b1, 1'b1, 2'b01, 32'h1111, 32'hA5A5A5A5, 32'h0, 5'd3, 5'd7, 5'd3,
                   32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 5'd3, 32'd2};
        tbl[2] = '{1'b1, 1'b1, 2'b10, 32'h2222, 32'h3333, 32'h00400010, 5'd31, 5'd3, 5'd31,
                   32'hA5A5A5A5, 32'h00400010, 32'h00400010, 1'b1, 5'd31, 32'd3};
        tbl[3] = '{1'b1, 1'b1, 2'b11, 32'h0BADF00D, 32'h22, 32'h33, 5'd4, 5'd31, 5'd4,
                   32'h00400010, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 5'd4, 32'd4};
        tbl[4] = '{1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd5};
        tbl[5] = '{1'b0, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd9, 5'd4, 5'd9,
                   32'h0BADF00D, 32'h0, 32'h55, 1'b0, 5'd0, 32'd5};
        tbl[6] = '{1'b1, 1'b0, 2'b00, 32'h77, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9,
                   32'h0, 32'h0, 32'h77, 1'b0, 5'd0, 32'd6};
        tbl[7] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd3,
                   32'hDEADBEEF, 32'hA5A5A5A5, 32'h0, 1'b0, 5'd0, 32'd6};
        tbl[8] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd31,
                   32'h00400010, 32'h00400010, 32'h0, 1'b0, 5'd0, 32'd6};
        tbl[9] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd9,
                   32'h0BADF00D, 32'h0, 32'h0, 1'b0, 5'd0, 32'd6};

        // Power-on reset
        idle(5'd0, 5'd0);
        rst = 1'b1;
        m_clear();
        repeat (2) @(negedge clk);
        #1;
        check("por instret", bus.instret, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].valid, tbl[i].rw, tbl[i].sel, tbl[i].alu, tbl[i].mem, tbl[i].pc4,
                   tbl[i].dst, tbl[i].ra1, tbl[i].ra2);
            #1;
            check($sformatf("tbl%0d rd1", i),     bus.rd1,                tbl[i].e_rd1);
            check($sformatf("tbl%0d rd2", i),     bus.rd2,                tbl[i].e_rd2);
            check($sformatf("tbl%0d result", i),  bus.result_wb,          tbl[i].e_res);
            check($sformatf("tbl%0d fwd_we", i),  {31'd0, bus.fwd_we_wb}, {31'd0, tbl[i].e_we});
            check($sformatf("tbl%0d fwd_dst", i), {27'd0, bus.fwd_dst_wb}, {27'd0, tbl[i].e_dst});
            tick();
            #1;
            check($sformatf("tbl%0d instret", i), bus.instret, tbl[i].e_cnt);
        end

        // Mid-run async reset: r5 is lost, pending write to r6 is aborted
        set_in(1'b1, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0);
        tick();
        idle(5'd5, 5'd0);
        #1;
        check("pre-reset r5", bus.rd1, 32'h1234);
        set_in(1'b1, 1'b1, 2'b00, 32'hCAFE, 32'h0, 32'h0, 5'd6, 5'd5, 5'd6);
        #1;
        rst = 1'b1;
        m_clear();
        #1;
        check("in-reset r5", bus.rd1, 32'd0);
        check("in-reset instret", bus.instret, 32'd0);
        check("in-reset result", bus.result_wb, 32'hCAFE);
        check("in-reset bypass r6", bus.rd2, 32'hCAFE);
        tick();
        idle(5'd5, 5'd6);
        rst = 1'b0;
        #1;
        check("post-reset r5", bus.rd1, 32'd0);
        check("post-reset r6", bus.rd2, 32'd0);
        check("post-reset instret", bus.instret, 32'd0);
        set_in(1'b1, 1'b1, 2'b00, 32'h66, 32'h0, 32'h0, 5'd6, 5'd0, 5'd0);
        tick();
        idle(5'd6, 5'd5);
        #1;
        check("first write r6", bus.rd1, 32'h66);
        check("first write instret", bus.instret, 32'd1);

        // Counter wrap
        dut.instret_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        set_in(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        idle(5'd0, 5'd0);
        #1;
        check("instret wrap", bus.instret, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] dst;
            dst = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) dst = 5'($urandom_range(0, 3));
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, dst,
                   ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31)));
            rst = ($urandom_range(0, 63) == 0);
            if (rst) m_clear();
            #1;
            check_model($sformatf("rnd%0d", n));
            tick();
        end
        rst = 1'b0;
        idle(5'd0, 5'd0);
        #1;
        check("final instret", bus.instret, m_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register.
- Selects the writeback result (ALU, load data or link address) and commits it to the 32-entry general-purpose register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Exports the effective writeback destination and value to the hazard/forwarding unit.
- Keeps a retired-instruction counter.

Parameters:
- DATA_W, 32 (PC_BITS from CPU_def): datapath width.
- REG_ADDR_W, 5: register index width.
- NUM_REGS, 32: architectural register count; must equal 2**REG_ADDR_W.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_write_wb  in  1  instruction in WB writes a register.
- mem_to_reg_wb  in  2  result select: 00 ALU, 01 load data, 10 PC+4 (link), 11 reserved.
- alu_out_wb  in  DATA_W  ALU result from MEM/WB.
- read_data_wb  in  DATA_W  load data from MEM/WB.
- pc_plus_4wb  in  DATA_W  link address from MEM/WB.
- write_reg_wb  in  REG_ADDR_W  destination register index.
- valid_wb  in  1  WB slot holds a real instruction (0 = bubble).
- ra1  in  REG_ADDR_W  decode read address, port 1.
- ra2  in  REG_ADDR_W  decode read address, port 2.
- rd1  out  DATA_W  read data, port 1 (combinational).
- rd2  out  DATA_W  read data, port 2 (combinational).
- result_wb  out  DATA_W  selected writeback value (combinational).
- fwd_we_wb  out  1  effective write enable, for the forwarding unit.
- fwd_dst_wb  out  REG_ADDR_W  effective destination, for the forwarding unit.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset: asynchronous, active-high.
  - While rst=1: all NUM_REGS entries = 0 and instret = 0.
  - Combinational outputs still follow inputs during reset.
  - Reset asserted mid-operation aborts any pending write; the first write after deassertion is the first rising edge with rst=0.
- Result select:
  - result_wb = alu_out_wb for 00, read_data_wb for 01, pc_plus_4wb for 10.
  - 11 is reserved and selects alu_out_wb; no error flag.
- Effective write enable:
  - we = reg_write_wb & valid_wb & (write_reg_wb != 0).
  - fwd_we_wb = we; fwd_dst_wb = write_reg_wb when we=1, else 0.
- Write:
  - On a rising edge with we=1, regs[write_reg_wb] <= result_wb.
  - Latency: one edge.
- Register 0:
  - Hardwired zero; never written.
  - Reads of index 0 always return 0, even when a bypass matches.
- Read:
  - rdN = 0 if raN == 0.
  - Otherwise rdN = result_wb if we && raN == write_reg_wb (write-through bypass, same cycle).
  - Otherwise rdN = regs[raN].
  - Both ports are independent; ra1 == ra2 is legal and returns identical data.
- Retire counter:
  - instret increments by 1 on each rising edge with valid_wb=1, regardless of reg_write_wb.
  - 32-bit, wraps from 0xFFFF_FFFF to 0 with no flag.
- Bubbles:
  - valid_wb=0 with reg_write_wb=1 performs no write, no bypass, and no count.
- Freezing:
  - No stall input. Upstream holds MEM/WB contents during stalls; the upstream stage deasserts valid_wb for repeated cycles, so the same instruction is not retired twice.
- Fully synchronous single-edge design; no negedge writes.

Decomposition:
- CPU_def package holds:
  - PC_BITS
  - REG_ADDR_W
  - NUM_REGS
  - WB_SEL_ALU / WB_SEL_MEM / WB_SEL_PC4 localparams (2-bit encodings)
  - REG_ZERO = 0
  - REG_RA = 31, used by the earlier stages for link destination
- Natural sub-module: regfile_2r1w.
  - Storage, reset, $0 handling and bypass.
  - Instantiated by wb_regfile alongside the result mux and instret counter.

Test Plan:
- Reset/readback:
  - Assert rst mid-run after writing r5=0x1234.
  - Required: ra1=5 gives rd1=0 during and after reset; instret=0.
- ALU writeback and bypass:
  - valid=1, reg_write=1, sel=00, alu_out=0xDEADBEEF, dst=7, ra1=7.
  - Required: rd1=0xDEADBEEF the same cycle.
  - Required: after the edge with inputs idle, rd1 still 0xDEADBEEF and instret=1.
- Load and link select:
  - sel=01, read_data=0xA5A5A5A5, dst=3, then sel=10, pc_plus_4=0x0040_0010, dst=31.
  - Required: r3=0xA5A5A5A5, r31=0x0040_0010; sel=11 writes alu_out.
- Register zero:
  - Write 0xFFFFFFFF to dst=0 with ra1=ra2=0.
  - Required: rd1=rd2=0, fwd_we_wb=0, and instret still increments.
- Bubble:
  - valid=0, reg_write=1, dst=9, alu_out=0x55.
  - Required: r9 unchanged, no bypass on ra2=9, instret unchanged.
- Counter wrap:
  - Force instret=0xFFFF_FFFF, then one valid edge.
  - Required: instret=0.
